alu_sequential: RTL and testbench

- Multi-cycle ALU stage that sits directly upstream of the accumulator register.
- Takes the accumulator value and a second operand (memory or immediate), computes a `DATA_WIDTH+1`-bit result with the carry in the MSB, and holds it on `oAlu`. The accumulator captures `oAlu` on its ALU select path.
- Single-cycle logic/arithmetic ops finish in one cycle. Shift and multiply iterate one bit per cycle behind a start/busy/done handshake.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 53 +++++
 rtl/alu_sequential.sv | 152 +++++++++++++++
 tb/tb_alu_sequential.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU stage: opcode encoding,
// FSM state encoding and the opcode width.
package alu_seq_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul
// Shift-add multiplier datapath, one multiplier bit per step.
// Only compiled when ALU_SEQ_MUL_EN is defined.
// Ports:
//   Clock, Reset   clock, asynchronous active-low reset
//   load           capture a/b and clear the partial product
//   step           perform one shift-add iteration
//   a, b           multiplicand, multiplier
//   prod_lo        low half of the product
//   overflow       OR of the high half of the product
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] prod_lo,
    output logic                  overflow
);

    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [2*DATA_WIDTH-1:0] acc_plus;
    logic [DATA_WIDTH-1:0]   mplier;

    // Outputs include the add of the step in progress, so the caller can
    // register the final product on the same edge as the last step.
    assign acc_plus = acc + (mplier[0] ? mcand : '0);
    assign prod_lo  = acc_plus[DATA_WIDTH-1:0];
    assign overflow = |acc_plus[2*DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{DATA_WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (step) begin
            acc    <= acc_plus;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_sequential.sv
// alu_sequential
// Multi-cycle ALU stage feeding the accumulator. Single-cycle logic and
// arithmetic ops, iterative SHL, and (optionally) iterative MUL behind a
// start/busy/done handshake. Result carries carry/borrow/overflow in MSB.
// Optional feature: ALU_SEQ_MUL_EN enables the shift-add multiplier for
// opcode 7; without it opcode 7 is a single-cycle PASS B.
// Ports:
//   Clock, Reset   clock, asynchronous active-low reset
//   iStart         operation request (accepted in IDLE or DONE)
//   iOp            opcode
//   iA, iB         accumulator operand, second operand / shift amount
//   iCarry         carry input for ADC
//   oBusy          state is not IDLE
//   oDone          one-cycle result-valid pulse
//   oAlu           result, held between completions
//
// state | meaning
// IDLE  | waiting for iStart
// RUN   | iterating SHL or MUL, counter counts down to zero
// DONE  | oAlu just updated, oDone high; may accept a new op
module alu_sequential
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [OP_WIDTH-1:0]   iOp,
    input  logic [DATA_WIDTH-1:0] iA,
    input  logic [DATA_WIDTH-1:0] iB,
    input  logic                  iCarry,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [DATA_WIDTH:0]   oAlu
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]            state;
    logic [OP_WIDTH-1:0]   op_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  shamt;
    logic [CNT_WIDTH-1:0]  start_cnt;
    logic [DATA_WIDTH:0]   shreg;
    logic [DATA_WIDTH:0]   shreg_next;
    logic [DATA_WIDTH:0]   single_res;
    logic [DATA_WIDTH:0]   run_res;
    logic [DATA_WIDTH:0]   alu_q;
    logic                  accept;
    logic                  start_multi;

    assign shamt      = iB[CNT_WIDTH-1:0];
    assign accept     = iStart && ((state == S_IDLE) || (state == S_DONE));
    // Bit shifted out of the operand lands in the carry position.
    assign shreg_next = {shreg[DATA_WIDTH-1:0], 1'b0};

    always_comb begin
        single_res = {1'b0, iB};   // opcode 7 when not iterated: PASS B
        case (iOp)
            OP_ADD:  single_res = {1'b0, iA} + {1'b0, iB};
            OP_ADC:  single_res = {1'b0, iA} + {1'b0, iB} + {{DATA_WIDTH{1'b0}}, iCarry};
            OP_SUB:  single_res = {1'b0, iA} - {1'b0, iB};
            OP_AND:  single_res = {1'b0, iA & iB};
            OP_OR:   single_res = {1'b0, iA | iB};
            OP_XOR:  single_res = {1'b0, iA ^ iB};
            OP_SHL:  single_res = {1'b0, iA};   // shift by zero
            default: ;
        endcase
    end

    // Counter is loaded with iterations-1 and finishes on terminal count 0,
    // so DATA_WIDTH multiply steps fit in a CNT_WIDTH counter.
    always_comb begin
        start_multi = 1'b0;
        start_cnt   = shamt - CNT_WIDTH'(1);
        if ((iOp == OP_SHL) && (shamt != '0)) begin
            start_multi = 1'b1;
        end
`ifdef ALU_SEQ_MUL_EN
        if (iOp == OP_MUL) begin
            start_multi = 1'b1;
            start_cnt   = CNT_WIDTH'(DATA_WIDTH - 1);
        end
`endif
    end

`ifdef ALU_SEQ_MUL_EN
    logic [DATA_WIDTH-1:0] mul_lo;
    logic                  mul_ovf;

    alu_seq_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (accept && (iOp == OP_MUL)),
        .step     ((state == S_RUN) && (op_q == OP_MUL)),
        .a        (iA),
        .b        (iB),
        .prod_lo  (mul_lo),
        .overflow (mul_ovf)
    );

    assign run_res = (op_q == OP_MUL) ? {mul_ovf, mul_lo} : shreg_next;
`else
    assign run_res = shreg_next;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            op_q  <= '0;
            cnt   <= '0;
            shreg <= '0;
            alu_q <= '0;
        end else if (accept) begin
            op_q  <= iOp;
            shreg <= {1'b0, iA};
            if (start_multi) begin
                state <= S_RUN;
                cnt   <= start_cnt;
            end else begin
                state <= S_DONE;
                alu_q <= single_res;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (op_q == OP_SHL) begin
                        shreg <= shreg_next;
                    end
                    if (cnt == '0) begin
                        state <= S_DONE;
                        alu_q <= run_res;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oBusy = (state != S_IDLE);
    assign oDone = (state == S_DONE);
    assign oAlu  = alu_q;

endmodule

// File: tb/tb_alu_sequential.sv
// tb_alu_sequential
// Directed vector table plus hand-written multi-cycle sequences for
// alu_sequential with DATA_WIDTH=8. Expectations for opcode 7 follow
// whether ALU_SEQ_MUL_EN is defined.
module tb_alu_sequential;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iStart;
    logic [2:0] iOp;
    logic [7:0] iA;
    logic [7:0] iB;
    logic       iCarry;
    logic       oBusy;
    logic       oDone;
    logic [8:0] oAlu;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    alu_sequential #(
        .DATA_WIDTH (8)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .iCarry (iCarry),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oAlu   (oAlu)
    );

    // lat = clock edges after the accept edge until oDone is seen
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Presents the op and clocks the accept edge; returns 1 time unit after it.
    task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
        iOp    = op;
        iA     = a;
        iB     = b;
        iCarry = c;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!oDone && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int done_cnt;
        logic [8:0] prev;

        Reset  = 1'b0;
        iStart = 1'b0;
        iOp    = '0;
        iA     = '0;
        iB     = '0;
        iCarry = 1'b0;

        vecs.push_back(vec_t'{3'd0, 8'hFF, 8'h01, 1'b0, 9'h100, 0});
        vecs.push_back(vec_t'{3'd2, 8'h05, 8'h07, 1'b0, 9'h1FE, 0});
        vecs.push_back(vec_t'{3'd1, 8'h10, 8'h20, 1'b1, 9'h031, 0});
        vecs.push_back(vec_t'{3'd3, 8'hF0, 8'h3C, 1'b1, 9'h030, 0});
        vecs.push_back(vec_t'{3'd4, 8'hF0, 8'h0F, 1'b0, 9'h0FF, 0});
        vecs.push_back(vec_t'{3'd5, 8'hAA, 8'hFF, 1'b0, 9'h055, 0});
        vecs.push_back(vec_t'{3'd2, 8'h07, 8'h05, 1'b0, 9'h002, 0});
        vecs.push_back(vec_t'{3'd0, 8'h7F, 8'h01, 1'b1, 9'h080, 0});
        vecs.push_back(vec_t'{3'd1, 8'hFF, 8'h00, 1'b1, 9'h100, 0});
        vecs.push_back(vec_t'{3'd0, 8'h10, 8'h20, 1'b1, 9'h030, 0});
        vecs.push_back(vec_t'{3'd6, 8'h21, 8'h03, 1'b0, 9'h108, 3});
        vecs.push_back(vec_t'{3'd6, 8'h21, 8'h00, 1'b0, 9'h021, 0});
        vecs.push_back(vec_t'{3'd6, 8'h81, 8'h01, 1'b0, 9'h102, 1});
        vecs.push_back(vec_t'{3'd6, 8'h01, 8'h07, 1'b0, 9'h080, 7});
        vecs.push_back(vec_t'{3'd6, 8'h21, 8'h0B, 1'b0, 9'h108, 3});
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(vec_t'{3'd7, 8'h12, 8'h10, 1'b0, 9'h120, 8});
        vecs.push_back(vec_t'{3'd7, 8'h03, 8'h05, 1'b0, 9'h00F, 8});
        vecs.push_back(vec_t'{3'd7, 8'hFF, 8'hFF, 1'b0, 9'h101, 8});
`else
        vecs.push_back(vec_t'{3'd7, 8'h12, 8'h10, 1'b0, 9'h010, 0});
        vecs.push_back(vec_t'{3'd7, 8'h03, 8'h05, 1'b0, 9'h005, 0});
        vecs.push_back(vec_t'{3'd7, 8'hFF, 8'hFF, 1'b1, 9'h0FF, 0});
`endif

        // Reset state
        tick();
        check("rst_alu", 32'(oAlu), 32'h0);
        check("rst_busy", 32'(oBusy), 32'h0);
        check("rst_done", 32'(oDone), 32'h0);
        Reset = 1'b1;
        tick();

        // Vector table
        prev = 9'h000;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
            if (vecs[i].lat > 0) begin
                check($sformatf("v%0d_busy_run", i), 32'(oBusy), 32'h1);
                check($sformatf("v%0d_hold_run", i), 32'(oAlu), 32'(prev));
            end
            wait_done(0, lat);
            check($sformatf("v%0d_done", i), 32'(oDone), 32'h1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(oAlu), 32'(vecs[i].exp));
            prev = vecs[i].exp;
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(oDone), 32'h0);
            check($sformatf("v%0d_idle", i), 32'(oBusy), 32'h0);
            check($sformatf("v%0d_hold_idle", i), 32'(oAlu), 32'(prev));
        end

        // Back-to-back: start held through DONE accepts the next op
        iOp = 3'd1; iA = 8'h10; iB = 8'h20; iCarry = 1'b1; iStart = 1'b1;
        tick();
        check("b2b_done1", 32'(oDone), 32'h1);
        check("b2b_alu1", 32'(oAlu), 32'h031);
        iOp = 3'd3; iA = 8'hF0; iB = 8'h3C; iCarry = 1'b0;
        tick();
        check("b2b_done2", 32'(oDone), 32'h1);
        check("b2b_alu2", 32'(oAlu), 32'h030);
        iStart = 1'b0;
        tick();
        check("b2b_idle", 32'(oDone), 32'h0);

        // Start pulsed during SHL RUN is ignored; input changes have no effect
        apply(3'd6, 8'h21, 8'h03, 1'b0);
        iOp = 3'd0; iA = 8'h01; iB = 8'h01; iStart = 1'b1;
        tick();
        iStart = 1'b0; iA = 8'hFF; iB = 8'h00;
        check("ign_busy", 32'(oBusy), 32'h1);
        check("ign_nodone", 32'(oDone), 32'h0);
        check("ign_hold", 32'(oAlu), 32'h030);
        wait_done(1, lat);
        check("ign_latency", 32'(lat), 32'd3);
        check("ign_result", 32'(oAlu), 32'h108);
        tick();
        check("ign_idle", 32'(oBusy), 32'h0);

        // Reset during RUN aborts with no completion
`ifdef ALU_SEQ_MUL_EN
        apply(3'd7, 8'h12, 8'h10, 1'b0);
`else
        apply(3'd6, 8'h01, 8'h07, 1'b0);
`endif
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_pre", 32'(oBusy), 32'h1);
        check("mid_hold_pre", 32'(oAlu), 32'h108);
        Reset = 1'b0;
        #1;
        check("mid_rst_alu", 32'(oAlu), 32'h0);
        check("mid_rst_busy", 32'(oBusy), 32'h0);
        check("mid_rst_done", 32'(oDone), 32'h0);
        tick();
        Reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (oDone || oBusy) done_cnt++;
        end
        check("mid_no_done", 32'(done_cnt), 32'h0);
        apply(3'd0, 8'h01, 8'h02, 1'b0);
        check("post_rst_done", 32'(oDone), 32'h1);
        check("post_rst_alu", 32'(oAlu), 32'h003);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
